// File: rtl/cond_pkg.sv
// cond_pkg: condition codes, flag bit positions and flag-write group indices shared by the conditional-execution unit.
package cond_pkg;
    typedef enum logic [3:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
    } cond_e;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam int FW_NZ  = 1;
    localparam int FW_CV  = 0;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition check of a 4-bit condition field against {N,Z,C,V}.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic       w_n, w_z, w_c, w_v;
    logic [7:0] w_base;
    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];
    // Conditions come in complementary pairs: cond[0] inverts the even entry.
    // The top pair gives AL=1 and NV=0.
    assign w_base = {1'b1, ~w_z & ~(w_n ^ w_v), ~(w_n ^ w_v), w_c & ~w_z, w_v, w_n, w_c, w_z};
    assign pass   = w_base[cond[3:1]] ^ cond[0];
endmodule

// File: rtl/cond_exec_unit.sv
// cond_exec_unit: owns the NZCV flags, gates control strobes on the condition result.
// Optional saturating statistics counters under `define COND_STATS_EN.
module cond_exec_unit #(
    parameter int NUM_CTRL = 3,
    parameter int REG_OUT  = 0,
    parameter int STAT_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid,
    input  logic                flush,
    input  logic [3:0]          cond,
    input  logic [3:0]          alu_flags,
    input  logic [1:0]          flag_write,
    input  logic [NUM_CTRL-1:0] ctrl_in,
    output logic [NUM_CTRL-1:0] ctrl_out,
    output logic                cond_ex,
    output logic [3:0]          flags_q
`ifdef COND_STATS_EN
    ,
    output logic [STAT_W-1:0]   exec_count,
    output logic [STAT_W-1:0]   squash_count
`endif
);
    import cond_pkg::*;

    if (NUM_CTRL < 1 || NUM_CTRL > 16 || REG_OUT < 0 || REG_OUT > 1 || STAT_W < 1) begin : g_bad_param
        $error("cond_exec_unit: parameter out of range");
    end

    logic                r_flags_q_unused;
    logic [3:0]          r_flags;
    logic                w_pass, w_live, w_cond_ex;
    logic [NUM_CTRL-1:0] w_ctrl;

    assign r_flags_q_unused = 1'b0;

    cond_eval u_eval (
        .cond  (cond),
        .flags (r_flags),
        .pass  (w_pass)
    );

    // Reset also kills the live qualifier so combinational outputs drop at once.
    assign w_live    = valid & ~flush & ~reset;
    assign w_cond_ex = w_pass & w_live;
    assign w_ctrl    = w_cond_ex ? ctrl_in : '0;
    assign flags_q   = r_flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else if (w_cond_ex) begin
            if (flag_write[FW_NZ]) r_flags[FLAG_N:FLAG_Z] <= alu_flags[FLAG_N:FLAG_Z];
            if (flag_write[FW_CV]) r_flags[FLAG_C:FLAG_V] <= alu_flags[FLAG_C:FLAG_V];
        end
    end

    if (REG_OUT == 1) begin : g_reg
        logic [NUM_CTRL-1:0] r_ctrl;
        logic                r_cond_ex;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_ctrl    <= '0;
                r_cond_ex <= 1'b0;
            end else begin
                r_ctrl    <= w_ctrl;
                r_cond_ex <= w_cond_ex;
            end
        end
        assign ctrl_out = r_ctrl;
        assign cond_ex  = r_cond_ex;
    end else begin : g_comb
        assign ctrl_out = w_ctrl;
        assign cond_ex  = w_cond_ex;
    end

`ifdef COND_STATS_EN
    logic [STAT_W-1:0] r_exec, r_squash;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exec   <= '0;
            r_squash <= '0;
        end else begin
            if (w_cond_ex && r_exec != '1) r_exec <= r_exec + STAT_W'(1);
            if (w_live && !w_pass && r_squash != '1) r_squash <= r_squash + STAT_W'(1);
        end
    end
    assign exec_count   = r_exec;
    assign squash_count = r_squash;
`endif
endmodule

// File: tb/tb_cond_exec_unit.sv
// tb_cond_exec_unit: directed plus randomized check of combinational and registered variants against a flag model.
module tb_cond_exec_unit;
    import cond_pkg::*;
    localparam int NC = 3;
    localparam int SW = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0, reset = 1'b1, valid = 1'b0, flush = 1'b0;
    logic [3:0] cond = 4'd0, alu_flags = 4'd0;
    logic [1:0] flag_write = 2'd0;
    logic [NC-1:0] ctrl_in = '0;
    logic [NC-1:0] ctrl0, ctrl1;
    logic ex0, ex1;
    logic [3:0] fl0, fl1;
`ifdef COND_STATS_EN
    logic [SW-1:0] exc0, sq0, exc1, sq1;
`endif

    int checks = 0, errors = 0;
    logic [3:0] m_flags = 4'd0;
    logic [NC-1:0] m_ctrl_r = '0;
    logic m_ex_r = 1'b0;
    int m_exec = 0, m_sq = 0;

    always #5 clk = ~clk;

    cond_exec_unit #(.NUM_CTRL(NC), .REG_OUT(0), .STAT_W(SW)) u0 (
        .clk(clk), .reset(reset), .valid(valid), .flush(flush), .cond(cond),
        .alu_flags(alu_flags), .flag_write(flag_write), .ctrl_in(ctrl_in),
        .ctrl_out(ctrl0), .cond_ex(ex0), .flags_q(fl0)
`ifdef COND_STATS_EN
        , .exec_count(exc0), .squash_count(sq0)
`endif
    );

    cond_exec_unit #(.NUM_CTRL(NC), .REG_OUT(1), .STAT_W(SW)) u1 (
        .clk(clk), .reset(reset), .valid(valid), .flush(flush), .cond(cond),
        .alu_flags(alu_flags), .flag_write(flag_write), .ctrl_in(ctrl_in),
        .ctrl_out(ctrl1), .cond_ex(ex1), .flags_q(fl1)
`ifdef COND_STATS_EN
        , .exec_count(exc1), .squash_count(sq1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk_stats;
`ifdef COND_STATS_EN
        chk("exec0", 32'(exc0), 32'(m_exec));
        chk("squash0", 32'(sq0), 32'(m_sq));
        chk("exec1", 32'(exc1), 32'(m_exec));
        chk("squash1", 32'(sq1), 32'(m_sq));
`endif
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cyc(input logic v, input logic f, input logic [3:0] c, input logic [3:0] af,
                       input logic [1:0] fw, input logic [NC-1:0] ci);
        logic p, ex;
        logic [NC-1:0] co;
        valid = v; flush = f; cond = c; alu_flags = af; flag_write = fw; ctrl_in = ci;
        p  = ref_pass(c, m_flags);
        ex = p && v && !f;
        co = ex ? ci : '0;
        @(negedge clk);
        chk("ctrl0", 32'(ctrl0), 32'(co));
        chk("cond_ex0", 32'(ex0), 32'(ex));
        chk("flags0", 32'(fl0), 32'(m_flags));
        chk("ctrl1", 32'(ctrl1), 32'(m_ctrl_r));
        chk("cond_ex1", 32'(ex1), 32'(m_ex_r));
        chk("flags1", 32'(fl1), 32'(m_flags));
        chk_stats();
        @(posedge clk);
        #1;
        if (ex && fw[1]) m_flags[3:2] = af[3:2];
        if (ex && fw[0]) m_flags[1:0] = af[1:0];
        m_ctrl_r = co;
        m_ex_r   = ex;
        if (ex && m_exec < SMAX) m_exec++;
        if (v && !f && !p && m_sq < SMAX) m_sq++;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        #2;
        chk("rst_ctrl0", 32'(ctrl0), 0);
        chk("rst_ctrl1", 32'(ctrl1), 0);
        chk("rst_ex1", 32'(ex1), 0);
        chk("rst_flags", 32'(fl0), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_flags = 4'd0; m_ctrl_r = '0; m_ex_r = 1'b0; m_exec = 0; m_sq = 0;
        chk_stats();
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        cyc(1, 0, AL, 4'b0110, 2'b11, 3'b111);
        chk("al_flags", 32'(fl0), 32'h6);
        cyc(1, 0, AL, 4'b0100, 2'b11, 3'b101);
        cyc(1, 0, NE, 4'b1000, 2'b11, 3'b111);
        chk("ne_hold", 32'(fl0), 32'h4);
        cyc(1, 0, AL, 4'b1001, 2'b11, 3'b010);
        cyc(1, 0, GE, 4'b0000, 2'b00, 3'b111);
        cyc(1, 0, LT, 4'b0000, 2'b00, 3'b111);
        cyc(1, 0, AL, 4'b1111, 2'b11, 3'b001);
        cyc(1, 0, AL, 4'b0000, 2'b01, 3'b011);
        chk("partial", 32'(fl0), 32'hC);
        cyc(1, 1, AL, 4'b0011, 2'b11, 3'b111);
        cyc(1, 0, AL, 4'b0000, 2'b00, 3'b110);
        chk("flush_hold", 32'(fl0), 32'hC);
        cyc(1, 0, AL, 4'b0000, 2'b00, 3'b111);
        do_reset();
        for (int i = 0; i < 20; i++) cyc(1, 0, AL, 4'b0000, 2'b00, NC'($urandom));
        for (int i = 0; i < 3; i++) cyc(1, 0, EQ, 4'b0000, 2'b11, 3'b111);
        for (int i = 0; i < 5; i++) cyc(0, 0, AL, 4'b0000, 2'b11, 3'b111);
        cyc(1, 0, AL, 4'b0000, 2'b00, 3'b000);
`ifdef COND_STATS_EN
        chk("exec_sat", 32'(exc0), 15);
        chk("squash3", 32'(sq0), 3);
`endif
        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 96) do_reset();
            else cyc($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, 4'($urandom),
                     4'($urandom), 2'($urandom), NC'($urandom));
        end
        cyc(0, 0, AL, 4'b0000, 2'b00, 3'b000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
